// File: rtl/nios_sys_jtag_cmd_sync.sv
`default_nettype none
// ============================================================================
// nios_sys_jtag_cmd_sync : clk-side capture, queueing and one-hot decode of
//                          virtual-JTAG update-DR commands
// Revision: 1.0
// ============================================================================
module nios_sys_jtag_cmd_sync #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ACT_BIT     = 34
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        vs_udr,
  input  logic                        vs_uir,
  input  logic [IR_WIDTH-1:0]         ir_in,
  input  logic [SR_WIDTH-1:0]         sr,
  input  logic                        cmd_ready,
  input  logic                        overrun_clr,
  output logic [SR_WIDTH-1:0]         jdo,
  output logic [IR_WIDTH-1:0]         jdo_ir,
  output logic [(2**IR_WIDTH)-1:0]    take_action,
  output logic [(2**IR_WIDTH)-1:0]    take_no_action,
  output logic                        ir_update,
  output logic                        cmd_pending,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overrun
);

  localparam int c_NCH = 2**IR_WIDTH;
  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_EW  = IR_WIDTH + SR_WIDTH;

  generate
    if (SYNC_STAGES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        ACT_BIT < 0 || ACT_BIT >= SR_WIDTH) begin : g_param_check
      $error("nios_sys_jtag_cmd_sync: illegal parameter combination");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_prev;
  logic                   r_uir_prev;
  logic [c_AW:0]          r_wr_ptr;
  logic [c_AW:0]          r_rd_ptr;
  logic [c_EW-1:0]        r_mem [DEPTH];

  logic                   w_udr_rise;
  logic                   w_uir_rise;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [c_EW-1:0]        w_head;
  logic [c_NCH-1:0]       w_onehot;

  assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
  assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // A pop frees the slot the same cycle, so a full queue still accepts then.
  assign w_pop  = ~w_empty & cmd_ready;
  assign w_push = w_udr_rise & (~w_full | w_pop);
  assign w_drop = w_udr_rise & w_full & ~w_pop;

  assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_onehot = c_NCH'(1) << w_head[c_EW-1:SR_WIDTH];

  assign cmd_pending = ~w_empty;
  assign level       = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_prev <= 1'b0;
      r_uir_prev <= 1'b0;
      ir_update  <= 1'b0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
      r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
      ir_update  <= w_uir_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {ir_in, sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      jdo            <= '0;
      jdo_ir         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      overrun        <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr       <= r_rd_ptr + (c_AW+1)'(1);
        jdo            <= w_head[SR_WIDTH-1:0];
        jdo_ir         <= w_head[c_EW-1:SR_WIDTH];
        take_action    <= w_head[ACT_BIT] ? w_onehot : '0;
        take_no_action <= w_head[ACT_BIT] ? '0 : w_onehot;
      end else begin
        take_action    <= '0;
        take_no_action <= '0;
      end
      // Set has priority over clear.
      if (w_drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_sys_jtag_cmd_sync.sv
`default_nettype none
// ============================================================================
// tb_nios_sys_jtag_cmd_sync : directed self-checking bench, default parameters
// Revision: 1.0
// ============================================================================
module tb_nios_sys_jtag_cmd_sync;

  logic        clk;
  logic        reset_n;
  logic        vs_udr;
  logic        vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;
  logic        overrun_clr;
  logic [37:0] jdo;
  logic [1:0]  jdo_ir;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        ir_update;
  logic        cmd_pending;
  logic [2:0]  level;
  logic        overrun;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [37:0] c_ACT = 38'h04_0000_0000;

  nios_sys_jtag_cmd_sync u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .overrun_clr    (overrun_clr),
    .jdo            (jdo),
    .jdo_ir         (jdo_ir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_update      (ir_update),
    .cmd_pending    (cmd_pending),
    .level          (level),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One update-DR: high for 2 clk, low for 2 clk; push lands on edge 3,
  // a pop on edge 4 when cmd_ready is high.
  task automatic udr_send(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0;
    tick(2);
  endtask

  logic [1:0]  v_ir [5];
  logic [37:0] v_d  [5];

  initial begin
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; overrun_clr = 1'b0;
    tick(3);
    chk("rst_level", level, 0);
    chk("rst_pending", cmd_pending, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_ta", take_action, 0);
    chk("rst_tna", take_no_action, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_irupd", ir_update, 0);
    reset_n = 1'b1;
    tick(2);

    // Single command with latency checks
    cmd_ready = 1'b1;
    ir_in = 2'd2; sr = 38'h04_1234_5678; vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0;
    tick(1);
    chk("single_e3_ta", take_action, 4'b0000);
    chk("single_e3_level", level, 1);
    tick(1);
    chk("single_ta", take_action, 4'b0100);
    chk("single_tna", take_no_action, 4'b0000);
    chk("single_jdo", jdo, 38'h04_1234_5678);
    chk("single_jdo_ir", jdo_ir, 2);
    chk("single_level", level, 0);
    tick(1);
    chk("single_ta_1cyc", take_action, 4'b0000);
    chk("single_jdo_hold", jdo, 38'h04_1234_5678);
    chk("single_ir_hold", jdo_ir, 2);

    // No-action decode
    udr_send(2'd0, 38'h00_0000_00AB);
    chk("noact_tna", take_no_action, 4'b0001);
    chk("noact_ta", take_action, 4'b0000);
    chk("noact_jdo", jdo, 38'h00_0000_00AB);
    tick(1);
    chk("noact_tna_1cyc", take_no_action, 4'b0000);

    // Back-pressure: 3 queued, then drained in order
    cmd_ready = 1'b0;
    udr_send(2'd0, 38'h00_0000_0A00);
    udr_send(2'd1, c_ACT | 38'h0B00);
    udr_send(2'd3, 38'h00_0000_0C00);
    chk("bp_level", level, 3);
    chk("bp_pending", cmd_pending, 1);
    chk("bp_nopulse", {take_action, take_no_action}, 0);
    chk("bp_jdo_hold", jdo, 38'h00_0000_00AB);
    cmd_ready = 1'b1;
    tick(1);
    chk("bp_pop0_tna", take_no_action, 4'b0001);
    chk("bp_pop0_jdo", jdo, 38'h00_0000_0A00);
    tick(1);
    chk("bp_pop1_ta", take_action, 4'b0010);
    chk("bp_pop1_tna", take_no_action, 4'b0000);
    tick(1);
    chk("bp_pop2_tna", take_no_action, 4'b1000);
    chk("bp_pop2_jdo_ir", jdo_ir, 3);
    chk("bp_level0", level, 0);
    tick(1);
    chk("bp_idle", {take_action, take_no_action}, 0);
    chk("bp_pending0", cmd_pending, 0);

    // Overrun: 5 updates into a 4-deep queue
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v_ir[i] = 2'(i);
      v_d[i]  = 38'h00_0000_0010 + 38'(i);
      udr_send(v_ir[i], v_d[i]);
    end
    chk("ovr_level", level, 4);
    chk("ovr_flag", overrun, 1);
    ir_in = 2'd2; sr = 38'h3F_FFFF_FFFF; vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0; overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    chk("ovr_level_hold", level, 4);
    tick(1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("ovr_drain_jdo", jdo, v_d[i]);
      chk("ovr_drain_tna", take_no_action, 4'b0001 << v_ir[i]);
    end
    tick(1);
    chk("ovr_no5th", {take_action, take_no_action}, 0);
    chk("ovr_jdo_hold", jdo, v_d[3]);
    chk("ovr_empty", level, 0);

    // Full queue with push and pop in the same cycle; pointers wrap
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v_ir[i] = 2'(3 - i);
      v_d[i]  = c_ACT | (38'h100 + 38'(i));
      udr_send(v_ir[i], v_d[i]);
    end
    v_ir[4] = 2'd1; v_d[4] = 38'h00_0000_0555;
    chk("fpp_full", level, 4);
    ir_in = v_ir[4]; sr = v_d[4]; vs_udr = 1'b1;
    tick(2);
    vs_udr = 1'b0; cmd_ready = 1'b1;
    tick(1);
    chk("fpp_level", level, 4);
    chk("fpp_overrun", overrun, 0);
    chk("fpp_jdo0", jdo, v_d[0]);
    chk("fpp_ta0", take_action, 4'b1000);
    for (int i = 1; i < 5; i++) begin
      tick(1);
      chk("fpp_drain_jdo", jdo, v_d[i]);
    end
    chk("fpp_last_tna", take_no_action, 4'b0010);
    chk("fpp_empty", level, 0);

    // IR update pulse
    tick(1);
    vs_uir = 1'b1;
    tick(2);
    chk("uir_e2", ir_update, 0);
    vs_uir = 1'b0;
    tick(1);
    chk("uir_pulse", ir_update, 1);
    chk("uir_level", level, 0);
    tick(1);
    chk("uir_1cyc", ir_update, 0);

    // Reset mid-operation discards queued commands
    cmd_ready = 1'b0;
    udr_send(2'd2, c_ACT | 38'h777);
    udr_send(2'd3, 38'h888);
    chk("rmid_level", level, 2);
    #2;
    reset_n = 1'b0; cmd_ready = 1'b1;
    #1;
    chk("rmid_level0", level, 0);
    chk("rmid_pending0", cmd_pending, 0);
    chk("rmid_jdo0", jdo, 0);
    chk("rmid_pulses0", {take_action, take_no_action, ir_update}, 0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rmid_nopulse", {take_action, take_no_action}, 0);
    end
    chk("rmid_still_empty", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
